// File: rtl/mk_rst_pkg.sv
// Shared types and width helpers for the staggered reset sequencer.
package mk_rst_pkg;

  localparam logic [2:0] EncWaitLock = 3'd0;
  localparam logic [2:0] EncHold     = 3'd1;
  localparam logic [2:0] EncRelease  = 3'd2;
  localparam logic [2:0] EncRun      = 3'd3;
  localparam logic [2:0] EncHoldSw   = 3'd4;

  typedef enum logic [2:0] {
    StWaitLock = EncWaitLock,
    StHold     = EncHold,
    StRelease  = EncRelease,
    StRun      = EncRun,
    StHoldSw   = EncHoldSw
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mk_rst_seq_if.sv
// Local-bus facing signals of the reset sequencer.
interface mk_rst_seq_if #(
  parameter int unsigned N_OUT = 4,
  parameter int unsigned EVT_W = 8
);
  logic             sw_rst_req;
  logic [N_OUT-1:0] rst_out;
  logic             ready;
  logic             busy;
  logic [EVT_W-1:0] evt_cnt;
  logic [2:0]       state_o;

  modport master (
    input  sw_rst_req,
    output rst_out,
    output ready,
    output busy,
    output evt_cnt,
    output state_o
  );

  modport slave (
    output sw_rst_req,
    input  rst_out,
    input  ready,
    input  busy,
    input  evt_cnt,
    input  state_o
  );
endinterface

// File: rtl/rst_sync2.sv
// Two-flop synchroniser with synchronous active-low clear.
module rst_sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/mk_rst_seq.sv
// Reset stretcher: waits for lock, holds all resets, then releases them in index order.
module mk_rst_seq
  import mk_rst_pkg::*;
#(
  parameter int unsigned N_OUT          = 4,
  parameter int unsigned HOLD_CYCLES    = 65535,
  parameter int unsigned SW_HOLD_CYCLES = 16,
  parameter int unsigned STAGGER        = 8,
  parameter int unsigned EVT_W          = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           locked,
  mk_rst_seq_if.master   bus
);

  localparam int unsigned CntW  = cnt_width(max_u(HOLD_CYCLES, SW_HOLD_CYCLES));
  localparam int unsigned ScntW = cnt_width(STAGGER);
  localparam int unsigned IdxW  = cnt_width(N_OUT);

  localparam logic [CntW-1:0]  HoldLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]  SwHoldLast = CntW'(SW_HOLD_CYCLES - 1);
  localparam logic [ScntW-1:0] ScntLast   = (STAGGER == 0) ? '0 : ScntW'(STAGGER - 1);
  localparam logic [IdxW-1:0]  IdxLast    = IdxW'(N_OUT - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [ScntW-1:0]   scnt_q, scnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [N_OUT-1:0]   rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic [EVT_W-1:0]   evt_q, evt_d;
  logic               evt_inc;
  logic               locked_s;

  rst_sync2 u_lock_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (locked),
    .q    (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    evt_inc = 1'b0;

    // Lock loss outranks a software request in the same cycle.
    if (state_q != StWaitLock && !locked_s) begin
      state_d = StWaitLock;
      cnt_d   = '0;
      scnt_d  = '0;
      idx_d   = '0;
      evt_inc = 1'b1;
    end else if ((state_q == StRun || state_q == StRelease) && bus.sw_rst_req) begin
      state_d = StHoldSw;
      cnt_d   = '0;
      scnt_d  = '0;
      idx_d   = '0;
      evt_inc = 1'b1;
    end else begin
      unique case (state_q)
        StWaitLock: begin
          if (locked_s) begin
            state_d = StHold;
            cnt_d   = '0;
          end
        end
        StHold, StHoldSw: begin
          if (cnt_q == ((state_q == StHold) ? HoldLast : SwHoldLast)) begin
            state_d = StRelease;
            cnt_d   = '0;
            scnt_d  = '0;
            idx_d   = (STAGGER == 0) ? IdxLast : '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRelease: begin
          if (idx_q == IdxLast) begin
            state_d = StRun;
          end else if (scnt_q == ScntLast) begin
            scnt_d = '0;
            idx_d  = idx_q + IdxW'(1);
          end else begin
            scnt_d = scnt_q + ScntW'(1);
          end
        end
        StRun: ;
        default: begin
          state_d = StWaitLock;
          cnt_d   = '0;
          scnt_d  = '0;
          idx_d   = '0;
        end
      endcase
    end

    // Outputs are registered from the next state so nothing is combinational to the pins.
    rst_d = '1;
    if (state_d == StRun) begin
      rst_d = '0;
    end else if (state_d == StRelease) begin
      for (int k = 0; k < int'(N_OUT); k++) begin
        rst_d[k] = (k > int'(idx_d));
      end
    end
    ready_d = (state_d == StRun);
    busy_d  = (state_d != StRun);
    evt_d   = (evt_inc && evt_q != '1) ? evt_q + EVT_W'(1) : evt_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.rst_out = rst_q;
  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.evt_cnt = evt_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_mk_rst_seq.sv
// Directed bench: power-up, software reset, lock loss, collisions, saturation, zero stagger.
module tb_mk_rst_seq;
  logic clk = 1'b0;
  logic rstn0, locked0, rstn1, locked1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mk_rst_seq_if #(.N_OUT(4), .EVT_W(8)) if0 ();
  mk_rst_seq_if #(.N_OUT(4), .EVT_W(2)) if1 ();

  mk_rst_seq #(
    .N_OUT(4), .HOLD_CYCLES(10), .SW_HOLD_CYCLES(4), .STAGGER(3), .EVT_W(8)
  ) u_dut0 (
    .clk    (clk),
    .rstn   (rstn0),
    .locked (locked0),
    .bus    (if0)
  );

  mk_rst_seq #(
    .N_OUT(4), .HOLD_CYCLES(10), .SW_HOLD_CYCLES(4), .STAGGER(0), .EVT_W(2)
  ) u_dut1 (
    .clk    (clk),
    .rstn   (rstn1),
    .locked (locked1),
    .bus    (if1)
  );

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  initial begin
    rstn0 = 1'b0; locked0 = 1'b0; if0.sw_rst_req = 1'b0;
    rstn1 = 1'b0; locked1 = 1'b0; if1.sw_rst_req = 1'b0;

    // Power-up
    ticks(3);
    chk("reset_rst_out", 32'(if0.rst_out), 32'hF);
    chk("reset_ready",   32'(if0.ready),   32'h0);
    chk("reset_busy",    32'(if0.busy),    32'h1);
    chk("reset_evt",     32'(if0.evt_cnt), 32'h0);
    chk("reset_state",   32'(if0.state_o), 32'h0);
    rstn0 = 1'b1;
    locked0 = 1'b1;
    ticks(12);
    chk("pu_e12_rst",   32'(if0.rst_out), 32'hF);
    chk("pu_e12_state", 32'(if0.state_o), 32'h1);
    ticks(1);
    chk("pu_e13_rst",   32'(if0.rst_out), 32'hE);
    chk("pu_e13_state", 32'(if0.state_o), 32'h2);
    ticks(3);
    chk("pu_e16_rst",   32'(if0.rst_out), 32'hC);
    ticks(3);
    chk("pu_e19_rst",   32'(if0.rst_out), 32'h8);
    ticks(3);
    chk("pu_e22_rst",   32'(if0.rst_out), 32'h0);
    chk("pu_e22_ready", 32'(if0.ready),   32'h0);
    ticks(1);
    chk("pu_e23_ready", 32'(if0.ready),   32'h1);
    chk("pu_e23_busy",  32'(if0.busy),    32'h0);
    chk("pu_e23_state", 32'(if0.state_o), 32'h3);
    chk("pu_e23_evt",   32'(if0.evt_cnt), 32'h0);

    // Software reset pulse from RUN
    if0.sw_rst_req = 1'b1;
    ticks(1);
    if0.sw_rst_req = 1'b0;
    chk("sw_entry_rst",   32'(if0.rst_out), 32'hF);
    chk("sw_entry_ready", 32'(if0.ready),   32'h0);
    chk("sw_entry_evt",   32'(if0.evt_cnt), 32'h1);
    chk("sw_entry_state", 32'(if0.state_o), 32'h4);
    ticks(3);
    chk("sw_e3_rst", 32'(if0.rst_out), 32'hF);
    ticks(1);
    chk("sw_e4_rst", 32'(if0.rst_out), 32'hE);
    ticks(3);
    chk("sw_e7_rst", 32'(if0.rst_out), 32'hC);
    ticks(6);
    chk("sw_e13_rst", 32'(if0.rst_out), 32'h0);
    ticks(1);
    chk("sw_e14_ready", 32'(if0.ready), 32'h1);

    // Lock loss while only bit 0 is released
    if0.sw_rst_req = 1'b1;
    ticks(1);
    if0.sw_rst_req = 1'b0;
    ticks(4);
    chk("ll_pre_rst", 32'(if0.rst_out), 32'hE);
    locked0 = 1'b0;
    ticks(2);
    chk("ll_e2_rst",   32'(if0.rst_out), 32'hE);
    chk("ll_e2_state", 32'(if0.state_o), 32'h2);
    ticks(1);
    chk("ll_e3_rst",   32'(if0.rst_out), 32'hF);
    chk("ll_e3_state", 32'(if0.state_o), 32'h0);
    chk("ll_e3_evt",   32'(if0.evt_cnt), 32'h3);
    locked0 = 1'b1;
    ticks(12);
    chk("rl_e12_rst", 32'(if0.rst_out), 32'hF);
    ticks(1);
    chk("rl_e13_rst", 32'(if0.rst_out), 32'hE);
    ticks(9);
    chk("rl_e22_rst",   32'(if0.rst_out), 32'h0);
    chk("rl_e22_ready", 32'(if0.ready),   32'h0);
    ticks(1);
    chk("rl_e23_ready", 32'(if0.ready),   32'h1);
    chk("rl_e23_evt",   32'(if0.evt_cnt), 32'h3);

    // Lock loss and software request in the same cycle
    locked0 = 1'b0;
    ticks(2);
    chk("sim_pre_state", 32'(if0.state_o), 32'h3);
    if0.sw_rst_req = 1'b1;
    ticks(1);
    if0.sw_rst_req = 1'b0;
    chk("sim_state", 32'(if0.state_o), 32'h0);
    chk("sim_evt",   32'(if0.evt_cnt), 32'h4);
    chk("sim_rst",   32'(if0.rst_out), 32'hF);
    chk("sim_ready", 32'(if0.ready),   32'h0);
    ticks(1);
    chk("sim_after_evt",   32'(if0.evt_cnt), 32'h4);
    chk("sim_after_state", 32'(if0.state_o), 32'h0);

    // Synchronous reset during HOLD
    locked0 = 1'b1;
    ticks(5);
    chk("sr_hold_state", 32'(if0.state_o), 32'h1);
    rstn0 = 1'b0;
    ticks(1);
    rstn0 = 1'b1;
    chk("sr_rst",   32'(if0.rst_out), 32'hF);
    chk("sr_evt",   32'(if0.evt_cnt), 32'h0);
    chk("sr_state", 32'(if0.state_o), 32'h0);
    chk("sr_busy",  32'(if0.busy),    32'h1);
    ticks(2);
    chk("sr_sync_state", 32'(if0.state_o), 32'h0);
    ticks(1);
    chk("sr_hold2_state", 32'(if0.state_o), 32'h1);
    ticks(10);
    chk("sr_rel_rst",   32'(if0.rst_out), 32'hE);
    chk("sr_rel_state", 32'(if0.state_o), 32'h2);

    // Zero stagger, 2-bit saturating event counter
    rstn1 = 1'b1;
    locked1 = 1'b1;
    ticks(12);
    chk("z_e12_rst",   32'(if1.rst_out), 32'hF);
    chk("z_e12_state", 32'(if1.state_o), 32'h1);
    ticks(1);
    chk("z_e13_rst",   32'(if1.rst_out), 32'h0);
    chk("z_e13_state", 32'(if1.state_o), 32'h2);
    chk("z_e13_ready", 32'(if1.ready),   32'h0);
    ticks(1);
    chk("z_e14_ready", 32'(if1.ready),   32'h1);
    chk("z_e14_state", 32'(if1.state_o), 32'h3);
    for (int p = 1; p <= 5; p++) begin
      if1.sw_rst_req = 1'b1;
      ticks(1);
      if1.sw_rst_req = 1'b0;
      chk("sat_entry_state", 32'(if1.state_o), 32'h4);
      ticks(5);
      chk("sat_evt",   32'(if1.evt_cnt), (p < 3) ? 32'(p) : 32'h3);
      chk("sat_state", 32'(if1.state_o), 32'h3);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
